// File: rtl/cwe1262_lock_ctrl_if.sv
// Request/response handshake bundle between a bus master and the lock controller.
interface cwe1262_lock_ctrl_if #(
    parameter int unsigned AW     = 3,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_err
    );
endinterface

// File: rtl/cwe1262_lock_ctrl.sv
// Write front-end for a uniformly locked register bank: decodes single writes into a
// one-hot bank strobe or a sticky lock set, and counts lock-denied bank writes.
module cwe1262_lock_ctrl #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cwe1262_lock_ctrl_if.slave   bus,
    output logic                 we,
    output logic [NUM_BANKS-1:0] bank_sel,
    output logic [DATA_W-1:0]    wdata,
    output logic                 lock,
    output logic [CNT_W-1:0]     viol_cnt
);
    localparam int unsigned AW = $clog2(NUM_BANKS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic          set_q;

    logic req_bank_c;
    logic issue_bank_c;
    logic issue_lock_c;

    always_comb begin
        req_bank_c   = bus.req_addr < AW'(NUM_BANKS);
        issue_bank_c = addr_q < AW'(NUM_BANKS);
        issue_lock_c = addr_q == AW'(NUM_BANKS);
    end

    // The strobe is launched on the accepting edge so it is valid for exactly the
    // ISSUE cycle; lock cannot change on that edge, so it equals lock during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr_q         <= '0;
            set_q          <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            we             <= 1'b0;
            bank_sel       <= '0;
            wdata          <= '0;
            lock           <= 1'b0;
            viol_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state         <= ISSUE;
                        bus.req_ready <= 1'b0;
                        addr_q        <= bus.req_addr;
                        set_q         <= bus.req_wdata[0];
                        if (req_bank_c && !lock) begin
                            we       <= 1'b1;
                            bank_sel <= NUM_BANKS'(1) << bus.req_addr;
                            wdata    <= bus.req_wdata;
                        end
                    end
                end
                ISSUE: begin
                    state          <= RESP;
                    we             <= 1'b0;
                    bank_sel       <= '0;
                    wdata          <= '0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= !issue_lock_c && !(issue_bank_c && !lock);
                    if (issue_bank_c && lock && (viol_cnt != {CNT_W{1'b1}})) begin
                        viol_cnt <= viol_cnt + CNT_W'(1);
                    end
                    if (issue_lock_c && set_q) begin
                        lock <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.resp_err   <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cwe1262_lock_ctrl.sv
// Directed bench for cwe1262_lock_ctrl with a transaction-level reference model
// compared against the DUT on every falling clock edge.
module tb_cwe1262_lock_ctrl;
    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned AW        = 3;
    localparam int          VMAX      = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cwe1262_lock_ctrl_if #(.AW(AW), .DATA_W(DATA_W)) bus ();

    logic                 we;
    logic [NUM_BANKS-1:0] bank_sel;
    logic [DATA_W-1:0]    wdata;
    logic                 lock;
    logic [CNT_W-1:0]     viol_cnt;

    cwe1262_lock_ctrl #(.NUM_BANKS(NUM_BANKS), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .we(we), .bank_sel(bank_sel), .wdata(wdata), .lock(lock), .viol_cnt(viol_cnt)
    );

    int n_chk = 0;
    int n_err = 0;
    bit run   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: age = cycles since acceptance (-1 = no transaction in flight).
    int               m_age  = -1;
    bit               m_lock = 1'b0;
    int               m_viol = 0;
    bit               m_err  = 1'b0;
    bit               p_we, p_err, p_lockset, p_viol;
    logic [3:0]       p_sel;
    logic [31:0]      p_wdata;

    task automatic decide(input logic [2:0] a, input logic [31:0] d);
        p_we = 1'b0; p_err = 1'b0; p_lockset = 1'b0; p_viol = 1'b0;
        p_sel = '0; p_wdata = '0;
        if (int'(a) < NUM_BANKS) begin
            if (m_lock) begin
                p_err  = 1'b1;
                p_viol = 1'b1;
            end else begin
                p_we    = 1'b1;
                p_sel   = 4'(1 << a);
                p_wdata = d;
            end
        end else if (int'(a) == NUM_BANKS) begin
            p_lockset = d[0];
        end else begin
            p_err = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            bit strobe;
            if (!rst_n) begin
                m_age = -1; m_lock = 1'b0; m_viol = 0; m_err = 1'b0;
            end
            strobe = (m_age == 1) && p_we;
            chk("req_ready", 64'(bus.req_ready), 64'(m_age < 0));
            chk("we", 64'(we), 64'(strobe));
            chk("bank_sel", 64'(bank_sel), strobe ? 64'(p_sel) : 64'd0);
            chk("wdata", 64'(wdata), strobe ? 64'(p_wdata) : 64'd0);
            chk("resp_valid", 64'(bus.resp_valid), 64'(m_age == 2));
            if (m_age == 2 || !rst_n)
                chk("resp_err", 64'(bus.resp_err), (m_age == 2) ? 64'(m_err) : 64'd0);
            chk("lock", 64'(lock), 64'(m_lock));
            chk("viol_cnt", 64'(viol_cnt), 64'(m_viol));
            if (rst_n) begin
                case (m_age)
                    -1: if (bus.req_valid) begin
                        decide(bus.req_addr, bus.req_wdata);
                        m_age = 1;
                    end
                    1: begin
                        if (p_lockset) m_lock = 1'b1;
                        if (p_viol && m_viol < VMAX) m_viol++;
                        m_err = p_err;
                        m_age = 2;
                    end
                    2: if (bus.resp_ready) m_age = -1;
                    default: m_age = -1;
                endcase
            end
        end
    end

    // One complete write; called and returning at posedge+1 with the DUT idle.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input int stall,
                            output bit we_s, output logic [3:0] sel_s,
                            output logic [31:0] wd_s, output bit err_s);
        bit acc = 1'b0;
        we_s = 1'b0; sel_s = '0; wd_s = '0; err_s = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = bus.req_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            chk("handshake_timeout", 64'd0, 64'd1);
            bus.req_valid = 1'b0;
            return;
        end
        bus.req_valid = 1'b0;
        bus.req_addr  = ~a;
        bus.req_wdata = $urandom;
        if (stall > 0) bus.resp_ready = 1'b0;
        we_s = we; sel_s = bank_sel; wd_s = wdata;
        @(posedge clk); #1;
        err_s = bus.resp_err;
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        bit          w;
        logic [3:0]  s;
        logic [31:0] wd;
        bit          e;

        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        #2 rst_n = 1'b0;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_lock", 64'(lock), 64'd0);
        chk("rst_viol", 64'(viol_cnt), 64'd0);

        do_write(3'd2, 32'hDEADBEEF, 0, w, s, wd, e);
        chk("t1_we", 64'(w), 64'd1);
        chk("t1_sel", 64'(s), 64'b0100);
        chk("t1_wdata", 64'(wd), 64'hDEADBEEF);
        chk("t1_err", 64'(e), 64'd0);

        do_write(3'd1, 32'h1234_5678, 10, w, s, wd, e);
        chk("stall_sel", 64'(s), 64'b0010);
        chk("stall_err", 64'(e), 64'd0);

        do_write(3'd0, 32'hA5A5_0001, 0, w, s, wd, e);
        chk("b0_sel", 64'(s), 64'b0001);
        do_write(3'd3, 32'h0F0F_F0F0, 2, w, s, wd, e);
        chk("b3_wdata", 64'(wd), 64'h0F0F_F0F0);
        do_write(3'd6, 32'h1, 0, w, s, wd, e);
        chk("ill6_err", 64'(e), 64'd1);
        chk("ill6_we", 64'(w), 64'd0);
        chk("ill6_viol", 64'(viol_cnt), 64'd0);

        do_write(3'd4, 32'h0, 0, w, s, wd, e);
        chk("lk0_err", 64'(e), 64'd0);
        chk("lk0_lock", 64'(lock), 64'd0);
        do_write(3'd4, 32'h1, 0, w, s, wd, e);
        chk("lk1_err", 64'(e), 64'd0);
        chk("lk1_lock", 64'(lock), 64'd1);
        do_write(3'd4, 32'h1, 0, w, s, wd, e);
        chk("lk2_err", 64'(e), 64'd0);

        do_write(3'd0, 32'h5, 0, w, s, wd, e);
        chk("deny_we", 64'(w), 64'd0);
        chk("deny_err", 64'(e), 64'd1);
        chk("deny_viol", 64'(viol_cnt), 64'd1);

        for (int i = 0; i < 300; i++) begin
            do_write(3'(i % 4), 32'(i), 0, w, s, wd, e);
        end
        chk("sat_viol", 64'(viol_cnt), 64'd255);
        do_write(3'd7, 32'hFFFF_FFFF, 0, w, s, wd, e);
        chk("ill7_err", 64'(e), 64'd1);
        chk("ill7_we", 64'(w), 64'd0);
        chk("ill7_viol", 64'(viol_cnt), 64'd255);

        bus.req_valid = 1'b1;
        bus.req_addr  = 3'd3;
        bus.req_wdata = 32'hCAFE_0003;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_lock", 64'(lock), 64'd0);
        chk("mid_rst_viol", 64'(viol_cnt), 64'd0);
        chk("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("mid_rst_we", 64'(we), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_write(3'd3, 32'h0000_BEEF, 0, w, s, wd, e);
        chk("post_rst_we", 64'(w), 64'd1);
        chk("post_rst_sel", 64'(s), 64'b1000);
        chk("post_rst_err", 64'(e), 64'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
